// File: rtl/uart_rx_digito_if.sv
// uart_rx_digito_if: serial line in, received byte, digit value and status pulses out
interface uart_rx_digito_if;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic [7:0] digito;
  modport master (output rx_in, input data_out, data_valid, frame_error, busy, digito);
  modport slave  (input rx_in, output data_out, data_valid, frame_error, busy, digito);
endinterface

// File: rtl/uart_rx_digito.sv
// uart_rx_digito: 8N1 UART receiver mapping ASCII '0'-'9' to a held display digit
module uart_rx_digito #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_digito_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  state_t state, state_n;
  logic rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] sr, sr_n, data_n, digito_n;
  logic done, done_n, stop_ok, stop_ok_n, valid_n, ferr_n;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    sr_n      = sr;
    done_n    = done;
    stop_ok_n = stop_ok;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    data_n    = bus.data_out;
    digito_n  = bus.digito;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        done_n = 1'b0;
        state_n = (rx_d && !rx_s) ? START : IDLE;
      end
      START: if (cnt == MID) begin
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n     = '0;
        sr_n      = {rx_s, sr[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        state_n   = (bit_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (done) begin
        // outputs commit one cycle after the stop sample
        cnt_n    = '0;
        done_n   = 1'b0;
        valid_n  = stop_ok;
        ferr_n   = !stop_ok;
        state_n  = stop_ok ? IDLE : WAIT_HIGH;
        data_n   = stop_ok ? sr : bus.data_out;
        digito_n = !stop_ok ? bus.digito : (sr >= 8'h30 && sr <= 8'h39) ? sr - 8'h30 : 8'hFF;
      end else if (cnt == LAST) begin
        cnt_n     = '0;
        done_n    = 1'b1;
        stop_ok_n = rx_s;
      end
      WAIT_HIGH: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : WAIT_HIGH;
      end
      default: state_n = WAIT_HIGH;
    endcase
  end
  always_ff @(posedge clk) begin
    rx_m <= bus.rx_in;
    rx_s <= rx_m;
    rx_d <= rx_s;
    if (rst) begin
      rx_m            <= 1'b1;
      rx_s            <= 1'b1;
      rx_d            <= 1'b1;
      state           <= WAIT_HIGH;
      cnt             <= '0;
      bit_idx         <= '0;
      sr              <= '0;
      done            <= 1'b0;
      stop_ok         <= 1'b0;
      bus.data_out    <= '0;
      bus.digito      <= '0;
      bus.data_valid  <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      bit_idx         <= bit_idx_n;
      sr              <= sr_n;
      done            <= done_n;
      stop_ok         <= stop_ok_n;
      bus.data_out    <= data_n;
      bus.digito      <= digito_n;
      bus.data_valid  <= valid_n;
      bus.frame_error <= ferr_n;
      bus.busy        <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_rx_digito.sv
// tb_uart_rx_digito: directed frames with hand-computed expectations at N = 8
module tb_uart_rx_digito;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;
  int cyc = 0, vcnt = 0, fcnt = 0, both = 0, t_start = 0, t_valid = 0;
  logic busy_seen = 1'b0;
  logic [7:0] last_dig = 8'h00, prev_dig = 8'h00;
  uart_rx_digito_if bus();
  uart_rx_digito #(.CLKS_PER_BIT(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) begin
    if (bus.data_valid) begin
      vcnt++;
      t_valid  = cyc;
      prev_dig = last_dig;
      last_dig = bus.digito;
    end
    if (bus.frame_error) fcnt++;
    if (bus.data_valid && bus.frame_error) both++;
    if (bus.busy) busy_seen = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    t_start = cyc + 1;
    bus.rx_in = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = b[i];
      repeat (N) @(negedge clk);
    end
    bus.rx_in = stop;
    repeat (N) @(negedge clk);
  endtask
  initial begin
    int lat;
    bus.rx_in = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_digito", bus.digito, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid_cnt", vcnt, 0);
    chk("rst_ferr_cnt", fcnt, 0);
    send_byte(8'h35, 1'b1);
    wait_cyc(4);
    lat = t_valid - t_start;
    chk("d5_valid_cnt", vcnt, 1);
    chk("d5_data", bus.data_out, 8'h35);
    chk("d5_digito", bus.digito, 8'h05);
    chk("d5_ferr_cnt", fcnt, 0);
    chk("d5_latency_ok", (lat >= 2 + N/2 + 9*N + 1 - 2) && (lat <= 2 + N/2 + 9*N + 1 + 2), 1'b1);
    send_byte(8'h37, 1'b0);
    repeat (3*N) @(negedge clk);
    #1;
    chk("fe_busy_hold", bus.busy, 1'b1);
    chk("fe_ferr_cnt", fcnt, 1);
    chk("fe_valid_cnt", vcnt, 1);
    chk("fe_data", bus.data_out, 8'h35);
    chk("fe_digito", bus.digito, 8'h05);
    bus.rx_in = 1'b1;
    wait_cyc(6);
    chk("fe_busy_release", bus.busy, 1'b0);
    send_byte(8'h41, 1'b1);
    wait_cyc(4);
    chk("a_valid_cnt", vcnt, 2);
    chk("a_data", bus.data_out, 8'h41);
    chk("a_digito", bus.digito, 8'hFF);
    busy_seen = 1'b0;
    bus.rx_in = 1'b0;
    wait_cyc(2);
    bus.rx_in = 1'b1;
    wait_cyc(N);
    chk("gl_busy_seen", busy_seen, 1'b1);
    chk("gl_busy_idle", bus.busy, 1'b0);
    chk("gl_valid_cnt", vcnt, 2);
    chk("gl_ferr_cnt", fcnt, 1);
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    wait_cyc(4);
    chk("b2b_valid_cnt", vcnt, 4);
    chk("b2b_first_digit", prev_dig, 8'h01);
    chk("b2b_second_digit", last_dig, 8'h02);
    chk("b2b_data", bus.data_out, 8'h32);
    bus.rx_in = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx_in = i[0];
      repeat (N) @(negedge clk);
    end
    bus.rx_in = 1'b1;
    repeat (N/2) @(negedge clk);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(2*N);
    chk("mid_rst_data", bus.data_out, 8'h00);
    chk("mid_rst_digito", bus.digito, 8'h00);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_valid_cnt", vcnt, 4);
    chk("mid_rst_ferr_cnt", fcnt, 1);
    chk("never_both", both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
